// File: rtl/uart16550_wb_sequencer_pkg.sv
// Shared definitions for the UART 16550 Wishbone sequencer.
// Contents:
//   - UART register word addresses as seen on the 4-bit Wishbone address
//   - position of the THRE flag inside LSR
//   - the DLAB bit of LCR
//   - the sequencer FSM state enum and a helper that tells which states
//     own a bus access
package uart16550_wb_sequencer_pkg;

  localparam logic [3:0] ADR_THR = 4'd0;
  localparam logic [3:0] ADR_DLL = 4'd0;
  localparam logic [3:0] ADR_DLM = 4'd1;
  localparam logic [3:0] ADR_FCR = 4'd2;
  localparam logic [3:0] ADR_LCR = 4'd3;
  localparam logic [3:0] ADR_LSR = 4'd5;

  localparam int LSR_THRE_BIT = 5;

  localparam logic [7:0] LCR_DLAB = 8'h80;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LCR_DLAB,
    ST_DLL,
    ST_DLM,
    ST_LCR,
    ST_FCR,
    ST_READY,
    ST_POLL,
    ST_WRITE,
    ST_ERROR
  } seq_state_e;

  // True for every state that performs exactly one Wishbone access
  // per visit (configuration writes, LSR poll and THR write).
  function automatic logic is_bus_state(seq_state_e s);
    return (s != ST_IDLE) && (s != ST_READY) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/uart16550_wb_sequencer_seq_tx_fifo.sv
// Synchronous single-clock byte FIFO feeding the THR writer.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (empties the FIFO)
//   push, din    write a byte; ignored while full
//   pop, dout    dout shows the head; pop removes it; ignored while empty
//   full, empty  occupancy flags
//   count        number of stored bytes (FIFO_ADDR_W+1 bits)
module seq_tx_fifo #(
  parameter int FIFO_ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [FIFO_ADDR_W:0]   count
);

  localparam int DEPTH = 1 << FIFO_ADDR_W;

  logic [7:0]             mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr;
  logic [FIFO_ADDR_W-1:0] rd_ptr;
  logic                   push_ok;
  logic                   pop_ok;

  assign full    = (count == (FIFO_ADDR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage has no reset; emptiness is defined purely by the count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth. A simultaneous
  // push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart16550_wb_sequencer.sv
// Wishbone master that configures a UART 16550 and then streams bytes
// from an internal FIFO into THR, polling LSR.THRE between bursts.
// Ports:
//   WBs_CLK_i, WBs_RST_i    clock, asynchronous active-high reset
//   Start_i, Clear_Err_i    control pulses
//   Tx_Data_i, Tx_Push_i    byte producer interface
//   Tx_Full_o               FIFO full
//   Init_Done_o             configuration finished (READY/POLL/WRITE)
//   Busy_o                  sequencing or bytes still queued
//   Timeout_Err_o           sticky ACK timeout flag
//   WBm_*                   Wishbone master towards the UART
module uart16550_wb_sequencer
  import uart16550_wb_sequencer_pkg::*;
#(
  parameter logic [15:0] DIVISOR     = 16'd6,
  parameter logic [7:0]  LCR_VALUE   = 8'h03,
  parameter logic [7:0]  FCR_VALUE   = 8'h07,
  parameter int          FIFO_ADDR_W = 3,
  parameter int          TX_BURST    = 16,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic        Start_i,
  input  logic        Clear_Err_i,
  input  logic [7:0]  Tx_Data_i,
  input  logic        Tx_Push_i,
  output logic        Tx_Full_o,
  output logic        Init_Done_o,
  output logic        Busy_o,
  output logic        Timeout_Err_o,
  output logic [3:0]  WBm_ADR_o,
  output logic        WBm_CYC_o,
  output logic        WBm_STB_o,
  output logic        WBm_WE_o,
  output logic [7:0]  WBm_DAT_o,
  input  logic [15:0] WBm_DAT_i,
  input  logic        WBm_ACK_i
);

  localparam int BURST_W = $clog2(TX_BURST + 1);

  seq_state_e           state_q, state_n;
  logic                 cyc_q, cyc_n;
  logic [3:0]           adr_q, adr_n;
  logic                 we_q, we_n;
  logic [7:0]           dat_q, dat_n;
  logic                 err_q, err_n;
  logic [7:0]           tmo_q, tmo_n;
  logic [BURST_W-1:0]   burst_q, burst_n;
  logic [BURST_W-1:0]   burst_inc;

  logic [3:0]           req_adr;
  logic                 req_we;
  logic [7:0]           req_dat;

  logic                 fifo_pop;
  logic [7:0]           fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FIFO_ADDR_W:0] fifo_count;
  logic                 last_byte;
  logic                 thre;
  logic                 unused_dat;

  seq_tx_fifo #(
    .FIFO_ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk   (WBs_CLK_i),
    .rst   (WBs_RST_i),
    .push  (Tx_Push_i),
    .pop   (fifo_pop),
    .din   (Tx_Data_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The byte being popped is the last one unless a push lands in the
  // same cycle (a push at count 1 is never blocked by full).
  assign last_byte  = (fifo_count == (FIFO_ADDR_W + 1)'(1)) && !Tx_Push_i;
  assign thre       = WBm_DAT_i[LSR_THRE_BIT];
  assign burst_inc  = burst_q + BURST_W'(1);
  assign unused_dat = ^{WBm_DAT_i[15:LSR_THRE_BIT+1], WBm_DAT_i[LSR_THRE_BIT-1:0]};

  assign WBm_CYC_o     = cyc_q;
  assign WBm_STB_o     = cyc_q;
  assign WBm_ADR_o     = adr_q;
  assign WBm_WE_o      = we_q;
  assign WBm_DAT_o     = dat_q;
  assign Timeout_Err_o = err_q;
  assign Tx_Full_o     = fifo_full;
  assign Init_Done_o   = (state_q == ST_READY) || (state_q == ST_POLL) || (state_q == ST_WRITE);
  assign Busy_o        = ((state_q != ST_IDLE) && (state_q != ST_READY)) || !fifo_empty;

  // Address / direction / data that each bus-owning state presents.
  always_comb begin
    req_adr = '0;
    req_we  = 1'b0;
    req_dat = '0;
    case (state_q)
      ST_LCR_DLAB: begin req_adr = ADR_LCR; req_we = 1'b1; req_dat = LCR_DLAB | LCR_VALUE; end
      ST_DLL:      begin req_adr = ADR_DLL; req_we = 1'b1; req_dat = DIVISOR[7:0]; end
      ST_DLM:      begin req_adr = ADR_DLM; req_we = 1'b1; req_dat = DIVISOR[15:8]; end
      ST_LCR:      begin req_adr = ADR_LCR; req_we = 1'b1; req_dat = LCR_VALUE & ~LCR_DLAB; end
      ST_FCR:      begin req_adr = ADR_FCR; req_we = 1'b1; req_dat = FCR_VALUE; end
      ST_POLL:     begin req_adr = ADR_LSR; req_we = 1'b0; req_dat = '0; end
      ST_WRITE:    begin req_adr = ADR_THR; req_we = 1'b1; req_dat = fifo_dout; end
      default:     begin req_adr = '0; req_we = 1'b0; req_dat = '0; end
    endcase
  end

  // Next-state logic. A bus state spends one cycle with CYC low (the
  // idle gap), raises CYC on that cycle's edge, then holds it until ACK
  // or timeout; the state only changes on the edge that drops CYC, so
  // consecutive accesses are always separated by an idle cycle.
  always_comb begin
    state_n  = state_q;
    cyc_n    = cyc_q;
    adr_n    = adr_q;
    we_n     = we_q;
    dat_n    = dat_q;
    err_n    = err_q;
    tmo_n    = tmo_q;
    burst_n  = burst_q;
    fifo_pop = 1'b0;

    if (is_bus_state(state_q)) begin
      if (!cyc_q) begin
        cyc_n = 1'b1;
        adr_n = req_adr;
        we_n  = req_we;
        dat_n = req_dat;
        tmo_n = '0;
      end else if (WBm_ACK_i) begin
        cyc_n = 1'b0;
        adr_n = '0;
        we_n  = 1'b0;
        dat_n = '0;
        tmo_n = '0;
        case (state_q)
          ST_LCR_DLAB: state_n = ST_DLL;
          ST_DLL:      state_n = ST_DLM;
          ST_DLM:      state_n = ST_LCR;
          ST_LCR:      state_n = ST_FCR;
          ST_FCR:      state_n = ST_READY;
          ST_POLL: begin
            if (thre) begin
              state_n = ST_WRITE;
              burst_n = '0;
            end
          end
          ST_WRITE: begin
            fifo_pop = 1'b1;
            burst_n  = burst_inc;
            if (last_byte) begin
              state_n = ST_READY;
            end else if (burst_inc == BURST_W'(TX_BURST)) begin
              state_n = ST_POLL;
            end
          end
          default: state_n = state_q;
        endcase
      end else if (tmo_q == ACK_TIMEOUT - 8'd1) begin
        cyc_n   = 1'b0;
        adr_n   = '0;
        we_n    = 1'b0;
        dat_n   = '0;
        tmo_n   = '0;
        err_n   = 1'b1;
        state_n = ST_ERROR;
      end else begin
        tmo_n = tmo_q + 8'd1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start_i) state_n = ST_LCR_DLAB;
        end
        ST_READY: begin
          if (!fifo_empty) state_n = ST_POLL;
        end
        ST_ERROR: begin
          if (Clear_Err_i) begin
            err_n   = 1'b0;
            state_n = ST_IDLE;
          end else if (Start_i) begin
            state_n = ST_LCR_DLAB;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State and registered bus outputs; reset drops CYC/STB immediately.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_n;
      cyc_q   <= cyc_n;
      adr_q   <= adr_n;
      we_q    <= we_n;
      dat_q   <= dat_n;
      err_q   <= err_n;
      tmo_q   <= tmo_n;
      burst_q <= burst_n;
    end
  end

endmodule

// File: tb/tb_uart16550_wb_sequencer.sv
// Scoreboard bench for uart16550_wb_sequencer: a UART slave model answers
// bus cycles, stimulus pushes the expected bus transactions into a queue,
// and a monitor pops and compares each access the DUT starts.
module tb_uart16550_wb_sequencer;

  localparam int TB_BURST       = 4;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int FIFO_DEPTH     = 8;

  typedef struct packed {
    logic [3:0] adr;
    logic       we;
    logic [7:0] dat;
  } bus_txn_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clear_err;
  logic [7:0]  tx_data;
  logic        tx_push;
  logic        tx_full;
  logic        init_done;
  logic        busy;
  logic        timeout_err;
  logic [3:0]  wb_adr;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [7:0]  wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack;

  bus_txn_t    exp_q[$];
  logic [15:0] lsr_resp_q[$];
  int          ack_delay  = 1;
  int          ack_limit  = -1;
  int          acks_given;
  int          checks_total  = 0;
  int          checks_passed = 0;

  uart16550_wb_sequencer #(
    .TX_BURST (TB_BURST)
  ) dut (
    .WBs_CLK_i     (clk),
    .WBs_RST_i     (rst),
    .Start_i       (start),
    .Clear_Err_i   (clear_err),
    .Tx_Data_i     (tx_data),
    .Tx_Push_i     (tx_push),
    .Tx_Full_o     (tx_full),
    .Init_Done_o   (init_done),
    .Busy_o        (busy),
    .Timeout_Err_o (timeout_err),
    .WBm_ADR_o     (wb_adr),
    .WBm_CYC_o     (wb_cyc),
    .WBm_STB_o     (wb_stb),
    .WBm_WE_o      (wb_we),
    .WBm_DAT_o     (wb_dat_o),
    .WBm_DAT_i     (wb_dat_i),
    .WBm_ACK_i     (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // UART slave: ACKs ack_delay cycles after CYC rises, answers LSR reads
  // from lsr_resp_q (THRE set once the queue is exhausted), and goes
  // silent after ack_limit acknowledges when ack_limit is non-negative.
  int wait_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack     <= 1'b0;
      wb_dat_i   <= 16'h0;
      wait_cnt   <= 0;
      acks_given <= 0;
    end else if (wb_cyc && !wb_ack) begin
      if (wait_cnt >= ack_delay - 1 && !(ack_limit >= 0 && acks_given >= ack_limit)) begin
        wb_ack     <= 1'b1;
        wait_cnt   <= 0;
        acks_given <= acks_given + 1;
        if (!wb_we && wb_adr == 4'd5) begin
          if (lsr_resp_q.size() > 0) wb_dat_i <= lsr_resp_q.pop_front();
          else                       wb_dat_i <= 16'h0020;
        end else begin
          wb_dat_i <= 16'h0;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wb_ack   <= 1'b0;
      wait_cnt <= 0;
    end
  end

  // Monitor: every rising CYC is matched against the scoreboard head, and
  // every CYC pulse length against the slave's configured response time.
  logic     prev_cyc = 1'b0;
  int       cyc_len  = 0;
  int       exp_len  = 0;
  bus_txn_t got;
  bus_txn_t want;
  always @(negedge clk) begin
    if (rst) begin
      prev_cyc = 1'b0;
      cyc_len  = 0;
    end else begin
      if (wb_cyc && !prev_cyc) begin
        checkOutput("stb_eq_cyc", {31'd0, wb_stb}, 32'd1);
        got = '{adr: wb_adr, we: wb_we, dat: wb_dat_o};
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_access", {19'd0, got}, 32'h1FFF);
        end else begin
          want = exp_q.pop_front();
          checkOutput("access_adr", {28'd0, got.adr}, {28'd0, want.adr});
          checkOutput("access_we", {31'd0, got.we}, {31'd0, want.we});
          if (want.we) checkOutput("access_dat", {24'd0, got.dat}, {24'd0, want.dat});
        end
        exp_len = (ack_limit >= 0 && acks_given >= ack_limit) ? TIMEOUT_CYCLES : ack_delay + 1;
        cyc_len = 1;
      end else if (wb_cyc) begin
        cyc_len++;
      end else if (prev_cyc) begin
        checkOutput("cyc_length", cyc_len, exp_len);
      end
      prev_cyc = wb_cyc;
    end
  end

  task automatic expectWrite(input logic [3:0] adr, input logic [7:0] dat);
    exp_q.push_back('{adr: adr, we: 1'b1, dat: dat});
  endtask

  task automatic expectInit();
    expectWrite(4'd3, 8'h83);
    expectWrite(4'd0, 8'h06);
    expectWrite(4'd1, 8'h00);
    expectWrite(4'd3, 8'h03);
    expectWrite(4'd2, 8'h07);
  endtask

  // Reference model for the drain: poll LSR until a THRE=1 answer, then
  // write up to TB_BURST bytes, repeat until every byte has been sent.
  task automatic expectTx(input logic [7:0] bytes[$], input logic [15:0] lsr[$]);
    int idx = 0;
    int i   = 0;
    logic [15:0] v;
    while (i < bytes.size()) begin
      do begin
        v = (idx < lsr.size()) ? lsr[idx] : 16'h0020;
        idx++;
        exp_q.push_back('{adr: 4'd5, we: 1'b0, dat: 8'h00});
      end while (!v[5]);
      for (int b = 0; b < TB_BURST && i < bytes.size(); b++) begin
        expectWrite(4'd0, bytes[i]);
        i++;
      end
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    start     = 1'b0;
    clear_err = 1'b0;
    tx_push   = 1'b0;
    tx_data   = 8'h00;
    ack_limit = -1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    lsr_resp_q.delete();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pushBytes(input logic [7:0] bytes[$]);
    foreach (bytes[k]) begin
      tx_push = 1'b1;
      tx_data = bytes[k];
      @(negedge clk);
    end
    tx_push = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulseClear(input logic with_start);
    clear_err = 1'b1;
    start     = with_start;
    @(negedge clk);
    clear_err = 1'b0;
    start     = 1'b0;
  endtask

  task automatic waitQuiet(input string name);
    int n = 0;
    while ((busy || wb_cyc) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_settles"}, {31'd0, n < 3000}, 32'd1);
    checkOutput({name, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One drain scenario after init: queue the LSR answers and bytes, let
  // the DUT send them, and compare the final status.
  task automatic applyStimulus(input string name, input logic [7:0] bytes[$],
                               input logic [15:0] lsr[$], input int delay);
    ack_delay  = delay;
    lsr_resp_q = lsr;
    expectTx(bytes, lsr);
    pushBytes(bytes);
    waitQuiet(name);
    checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_init_done"}, {31'd0, init_done}, 32'd1);
  endtask

  logic [7:0]  bytes_q[$];
  logic [15:0] lsr_q[$];
  logic [15:0] rv;
  int          found;

  initial begin
    $display("[TB] start");
    doReset();

    checkOutput("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    checkOutput("rst_stb", {31'd0, wb_stb}, 32'd0);
    checkOutput("rst_we", {31'd0, wb_we}, 32'd0);
    checkOutput("rst_adr", {28'd0, wb_adr}, 32'd0);
    checkOutput("rst_dat", {24'd0, wb_dat_o}, 32'd0);
    checkOutput("rst_full", {31'd0, tx_full}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("rst_err", {31'd0, timeout_err}, 32'd0);

    // Configuration sequence.
    ack_delay = 1;
    expectInit();
    pulseStart();
    checkOutput("init_busy", {31'd0, busy}, 32'd1);
    waitQuiet("init");
    checkOutput("init_done", {31'd0, init_done}, 32'd1);

    // Start is ignored once configured.
    pulseStart();
    waitCycles(5);
    checkOutput("start_ignored_cyc", {31'd0, wb_cyc}, 32'd0);

    bytes_q = '{8'h41, 8'h42, 8'h43};
    lsr_q   = '{16'h0060};
    applyStimulus("abc", bytes_q, lsr_q, 1);

    bytes_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    lsr_q   = '{16'h0000, 16'h0000, 16'h0000, 16'h0020};
    applyStimulus("thre_wait", bytes_q, lsr_q, 1);

    bytes_q.delete();
    for (int k = 0; k < 8; k++) bytes_q.push_back(8'($urandom));
    lsr_q.delete();
    applyStimulus("burst", bytes_q, lsr_q, 1);

    for (int r = 0; r < 6; r++) begin
      bytes_q.delete();
      lsr_q.delete();
      for (int k = 0; k < $urandom_range(1, 8); k++) bytes_q.push_back(8'($urandom));
      for (int k = 0; k < $urandom_range(0, 4); k++) begin
        rv = 16'($urandom);
        rv[5] = 1'($urandom_range(0, 1));
        lsr_q.push_back(rv);
      end
      applyStimulus($sformatf("rand%0d", r), bytes_q, lsr_q, $urandom_range(1, 3));
    end

    // FIFO fill while idle: ninth push is dropped, content is drained later.
    doReset();
    ack_delay = 1;
    bytes_q.delete();
    for (int k = 0; k < FIFO_DEPTH; k++) bytes_q.push_back(8'($urandom));
    pushBytes(bytes_q);
    checkOutput("full_after_8", {31'd0, tx_full}, 32'd1);
    tx_push = 1'b1;
    tx_data = 8'hEE;
    @(negedge clk);
    tx_push = 1'b0;
    checkOutput("full_after_9", {31'd0, tx_full}, 32'd1);
    checkOutput("full_busy", {31'd0, busy}, 32'd1);
    lsr_q.delete();
    expectInit();
    expectTx(bytes_q, lsr_q);
    pulseStart();
    waitQuiet("full");
    checkOutput("full_cleared", {31'd0, tx_full}, 32'd0);

    // ACK timeout on the DLL write.
    doReset();
    ack_delay = 1;
    ack_limit = 1;
    expectWrite(4'd3, 8'h83);
    expectWrite(4'd0, 8'h06);
    pulseStart();
    found = 0;
    while (!timeout_err && found < 1000) begin
      @(negedge clk);
      found++;
    end
    checkOutput("tmo_err", {31'd0, timeout_err}, 32'd1);
    checkOutput("tmo_cyc", {31'd0, wb_cyc}, 32'd0);
    checkOutput("tmo_busy", {31'd0, busy}, 32'd1);
    checkOutput("tmo_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("tmo_sb_empty", exp_q.size(), 32'd0);

    // Start from ERROR restarts the sequence while the flag stays set.
    expectWrite(4'd3, 8'h83);
    pulseStart();
    checkOutput("restart_err_kept", {31'd0, timeout_err}, 32'd1);
    waitCycles(300);
    checkOutput("restart_tmo_cyc", {31'd0, wb_cyc}, 32'd0);
    checkOutput("restart_sb_empty", exp_q.size(), 32'd0);
    pulseClear(1'b0);
    checkOutput("clear_err", {31'd0, timeout_err}, 32'd0);
    checkOutput("clear_busy", {31'd0, busy}, 32'd0);

    // Clear_Err and Start together in ERROR: clear wins, no new access.
    expectWrite(4'd3, 8'h83);
    pulseStart();
    waitCycles(300);
    checkOutput("err_again", {31'd0, timeout_err}, 32'd1);
    pulseClear(1'b1);
    checkOutput("clear_start_err", {31'd0, timeout_err}, 32'd0);
    waitCycles(20);
    checkOutput("clear_start_cyc", {31'd0, wb_cyc}, 32'd0);
    checkOutput("clear_start_busy", {31'd0, busy}, 32'd0);
    ack_limit = -1;

    // Reset in the middle of a THR write.
    doReset();
    ack_delay = 3;
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    lsr_q.delete();
    expectInit();
    expectTx(bytes_q, lsr_q);
    pushBytes(bytes_q);
    pulseStart();
    found = 0;
    while (!(wb_cyc && wb_we && wb_adr == 4'd0 && init_done) && found < 1000) begin
      @(negedge clk);
      found++;
    end
    checkOutput("thr_seen", {31'd0, found < 1000}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_cyc", {31'd0, wb_cyc}, 32'd0);
    checkOutput("midrst_stb", {31'd0, wb_stb}, 32'd0);
    checkOutput("midrst_we", {31'd0, wb_we}, 32'd0);
    checkOutput("midrst_adr", {28'd0, wb_adr}, 32'd0);
    checkOutput("midrst_dat", {24'd0, wb_dat_o}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("midrst_full", {31'd0, tx_full}, 32'd0);
    waitCycles(2);
    exp_q.delete();
    lsr_resp_q.delete();
    rst = 1'b0;
    waitCycles(10);
    checkOutput("postrst_cyc", {31'd0, wb_cyc}, 32'd0);
    checkOutput("postrst_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
